// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: FUNC3 encodings,
// FSM states and operand signedness decode.
package mdu_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } mdu_state_t;

    function automatic logic is_signed_op1(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    function automatic logic is_signed_op2(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/mdu_abs_neg.sv
// Conditional two's-complement negate; yields |x| for a negative signed input
// and applies the sign fix-up to a finished magnitude.
module mdu_abs_neg #(
    parameter int W = 32
) (
    input  logic [W-1:0] in_val,
    input  logic         negate,
    output logic [W-1:0] out_val
);

    assign out_val = negate ? (~in_val + W'(1)) : in_val;

endmodule

// File: rtl/mdu_iterative.sv
// Multi-cycle RV32M multiply/divide unit: 1-bit-per-cycle shift-add multiply
// and restoring divide on operand magnitudes, with a one-cycle sign fix-up.
module mdu_iterative
    import mdu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            START,
    input  logic            FLUSH,
    input  logic [2:0]      FUNC3,
    input  logic [XLEN-1:0] OPERAND1,
    input  logic [XLEN-1:0] OPERAND2,
    output logic            BUSYWAIT,
    output logic            DONE,
    output logic [XLEN-1:0] RESULT
);

    localparam logic [XLEN-1:0] MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = '1;
    localparam logic [XLEN-1:0] ZERO     = '0;

    mdu_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        func3_q, func3_d;
    logic [XLEN-1:0]   op_b_q, op_b_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic              neg_res_q, neg_res_d;
    logic              neg_rem_q, neg_rem_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              done_q, done_d;

    logic              op1_neg, op2_neg;
    logic [XLEN-1:0]   op1_abs, op2_abs;
    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic [2*XLEN-1:0] mul_next, div_next, prod_fix;
    logic [XLEN-1:0]   quot_fix, rem_fix, fix_result;

    assign op1_neg = is_signed_op1(FUNC3) && OPERAND1[XLEN-1];
    assign op2_neg = is_signed_op2(FUNC3) && OPERAND2[XLEN-1];

    mdu_abs_neg #(.W(XLEN)) u_abs_op1 (.in_val(OPERAND1), .negate(op1_neg), .out_val(op1_abs));
    mdu_abs_neg #(.W(XLEN)) u_abs_op2 (.in_val(OPERAND2), .negate(op2_neg), .out_val(op2_abs));

    // acc holds {high, low}: product/multiplier for multiply, remainder/quotient for divide.
    assign mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, op_b_q} : {1'b0, ZERO});
    assign mul_next  = {mul_sum, acc_q[XLEN-1:1]};
    assign div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    assign div_diff  = div_shift - {1'b0, op_b_q};
    assign div_next  = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                      : {div_diff[XLEN-1:0],  acc_q[XLEN-2:0], 1'b1};

    mdu_abs_neg #(.W(2*XLEN)) u_fix_prod (.in_val(acc_q), .negate(neg_res_q), .out_val(prod_fix));
    mdu_abs_neg #(.W(XLEN)) u_fix_quot (.in_val(acc_q[XLEN-1:0]), .negate(neg_res_q), .out_val(quot_fix));
    mdu_abs_neg #(.W(XLEN)) u_fix_rem (.in_val(acc_q[2*XLEN-1:XLEN]), .negate(neg_rem_q), .out_val(rem_fix));

    always_comb begin
        fix_result = quot_fix;
        case (func3_q)
            F3_MUL:                     fix_result = prod_fix[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: fix_result = prod_fix[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:            fix_result = quot_fix;
            default:                    fix_result = rem_fix;
        endcase
    end

    // Handshake: START is a request accepted in IDLE unless FLUSH; BUSYWAIT stalls
    // from that same cycle until DONE, a one-cycle pulse during which RESULT is valid.
    assign BUSYWAIT = ((state_q == S_IDLE) && START && !FLUSH) ||
                      (state_q == S_CALC) || (state_q == S_FIX);
    assign DONE     = done_q;
    assign RESULT   = result_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        func3_d   = func3_q;
        op_b_d    = op_b_q;
        acc_d     = acc_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        done_d    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (START && !FLUSH) begin
                    func3_d   = FUNC3;
                    cnt_d     = '0;
                    neg_res_d = op1_neg ^ op2_neg;
                    neg_rem_d = op1_neg;
                    state_d   = S_CALC;
                    if (FUNC3[2]) begin
                        op_b_d = op2_abs;
                        acc_d  = {ZERO, op1_abs};
                        // Fast paths preload the final unsigned halves and skip iteration.
                        if (OPERAND2 == ZERO) begin
                            acc_d     = {OPERAND1, ALL_ONES};
                            neg_res_d = 1'b0;
                            neg_rem_d = 1'b0;
                            state_d   = S_FIX;
                        end else if (is_signed_op2(FUNC3) && (OPERAND1 == MIN_INT) &&
                                     (OPERAND2 == ALL_ONES)) begin
                            acc_d     = {ZERO, MIN_INT};
                            neg_res_d = 1'b0;
                            neg_rem_d = 1'b0;
                            state_d   = S_FIX;
                        end
                    end else begin
                        op_b_d = op1_abs;
                        acc_d  = {ZERO, op2_abs};
                    end
                end
            end
            S_CALC: begin
                if (FLUSH) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = func3_q[2] ? div_next : mul_next;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(XLEN-1)) state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (FLUSH) begin
                    state_d = S_IDLE;
                end else begin
                    result_d = fix_result;
                    done_d   = 1'b1;
                    state_d  = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            func3_q   <= '0;
            op_b_q    <= '0;
            acc_q     <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            func3_q   <= func3_d;
            op_b_q    <= op_b_d;
            acc_q     <= acc_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
            done_q    <= done_d;
        end
    end

endmodule
